// File: rtl/madd_err_checker.sv
`default_nettype none
// ============================================================================
// Module  : madd_err_checker
// Brief   : Exhaustive 64-vector error sweep of an approximate 2x2-bit
//           multiply-add circuit. Optional macro MADD_CHK_TRACE_EN adds
//           first-failing-vector capture.
// Rev     : 1.0
// ============================================================================
module madd_err_checker #(
    parameter int DUT_LAT = 0,
    parameter int ET      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [5:0] vec_out,
    input  logic [3:0] approx_in,
    output logic       busy,
    output logic       done,
    output logic [3:0] max_err,
    output logic [9:0] err_sum,
    output logic [6:0] viol_cnt,
    output logic       pass,
    output logic [5:0] first_fail_vec,
    output logic       first_fail_valid
);

    localparam logic [3:0] c_ET         = 4'(ET);
    localparam logic [1:0] c_DRAIN_LAST = (DUT_LAT > 0) ? 2'(DUT_LAT - 1) : 2'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_cnt;
    logic [1:0] r_drain;
    logic [3:0] r_max;
    logic [9:0] r_sum;
    logic [6:0] r_viol;

    logic       w_start_ok;
    logic       w_cmp_vld;
    logic [5:0] w_cmp_vec;
    logic [3:0] w_exact;
    logic [3:0] w_err;
    logic       w_viol;

    assign w_start_ok = (r_state == IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_next = RUN;
            end
            RUN: begin
                if (r_cnt == 6'd63) w_next = (DUT_LAT > 0) ? DRAIN : DONE;
            end
            DRAIN: begin
                if (r_drain == c_DRAIN_LAST) w_next = DONE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Stage 0 of the expected-value pipeline is the vector being driven now.
    generate
        if (DUT_LAT == 0) begin : g_nolat
            assign w_cmp_vld = (r_state == RUN);
            assign w_cmp_vec = r_cnt;
        end else begin : g_lat
            logic [DUT_LAT-1:0] r_vld;
            logic [5:0]         r_vec [DUT_LAT];
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld <= '0;
                end else begin
                    r_vld[0] <= (r_state == RUN);
                    for (int i = 1; i < DUT_LAT; i++) r_vld[i] <= r_vld[i-1];
                end
                r_vec[0] <= r_cnt;
                for (int i = 1; i < DUT_LAT; i++) r_vec[i] <= r_vec[i-1];
            end
            assign w_cmp_vld = r_vld[DUT_LAT-1];
            assign w_cmp_vec = r_vec[DUT_LAT-1];
        end
    endgenerate

    assign w_exact = ({2'b00, w_cmp_vec[1:0]} * {2'b00, w_cmp_vec[3:2]}) + {2'b00, w_cmp_vec[5:4]};
    assign w_err   = (w_exact >= approx_in) ? (w_exact - approx_in) : (approx_in - w_exact);
    assign w_viol  = (w_err > c_ET);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_drain <= '0;
            r_max   <= '0;
            r_sum   <= '0;
            r_viol  <= '0;
        end else if (w_start_ok) begin
            r_cnt   <= '0;
            r_drain <= '0;
            r_max   <= '0;
            r_sum   <= '0;
            r_viol  <= '0;
        end else begin
            if (r_state == RUN)   r_cnt   <= r_cnt + 6'd1;
            if (r_state == DRAIN) r_drain <= r_drain + 2'd1;
            if (w_cmp_vld) begin
                if (w_err > r_max) r_max <= w_err;
                r_sum <= r_sum + {6'd0, w_err};
                if (w_viol) r_viol <= r_viol + 7'd1;
            end
        end
    end

`ifdef MADD_CHK_TRACE_EN
    logic [5:0] r_ff_vec;
    logic       r_ff_vld;
    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_ff_vec <= '0;
            r_ff_vld <= 1'b0;
        end else if (w_cmp_vld && w_viol && !r_ff_vld) begin
            r_ff_vec <= w_cmp_vec;
            r_ff_vld <= 1'b1;
        end
    end
    assign first_fail_vec   = r_ff_vec;
    assign first_fail_valid = r_ff_vld;
`else
    assign first_fail_vec   = 6'd0;
    assign first_fail_valid = 1'b0;
`endif

    assign vec_out  = (r_state == RUN) ? r_cnt : ((r_state == DRAIN) ? 6'd63 : 6'd0);
    assign busy     = (r_state == RUN) || (r_state == DRAIN);
    assign done     = (r_state == DONE);
    assign max_err  = r_max;
    assign err_sum  = r_sum;
    assign viol_cnt = r_viol;
    assign pass     = (r_max <= c_ET);

endmodule
`default_nettype wire

// File: tb/tb_madd_err_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_madd_err_checker
// Brief   : Random-stimulus bench for madd_err_checker at DUT_LAT 0 and 2.
// Rev     : 1.0
// ============================================================================
module tb_madd_err_checker;

    localparam int ET = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    int         mode;
    logic [3:0] rtab [64];
    int         n_tests = 0;
    int         n_fail  = 0;
    bit         chk_en  = 1'b0;

    logic [5:0] d_vec  [2];
    logic [3:0] d_apx  [2];
    logic       d_busy [2];
    logic       d_done [2];
    logic [3:0] d_max  [2];
    logic [9:0] d_sum  [2];
    logic [6:0] d_viol [2];
    logic       d_pass [2];
    logic [5:0] d_ffv  [2];
    logic       d_ffok [2];
    logic [5:0] r_dly1, r_dly2;

    always #5 clk = ~clk;

    function automatic int ex(input int v);
        return (v & 3) * ((v >> 2) & 3) + ((v >> 4) & 3);
    endfunction

    function automatic logic [3:0] fval(input int md, input logic [5:0] v, input logic [3:0] r);
        case (md)
            0:       return 4'(ex(int'(v)));
            1:       return 4'd0;
            2:       return 4'd15;
            default: return r;
        endcase
    endfunction

    // Approximate-circuit stand-ins: LAT 0 is combinational, LAT 2 sees the vector from two cycles ago.
    always @(posedge clk) begin
        r_dly1 <= d_vec[1];
        r_dly2 <= r_dly1;
    end
    assign d_apx[0] = fval(mode, d_vec[0], rtab[d_vec[0]]);
    assign d_apx[1] = fval(mode, r_dly2, rtab[r_dly2]);

    madd_err_checker #(.DUT_LAT(0), .ET(ET)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .vec_out(d_vec[0]), .approx_in(d_apx[0]),
        .busy(d_busy[0]), .done(d_done[0]), .max_err(d_max[0]), .err_sum(d_sum[0]),
        .viol_cnt(d_viol[0]), .pass(d_pass[0]), .first_fail_vec(d_ffv[0]),
        .first_fail_valid(d_ffok[0])
    );

    madd_err_checker #(.DUT_LAT(2), .ET(ET)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .vec_out(d_vec[1]), .approx_in(d_apx[1]),
        .busy(d_busy[1]), .done(d_done[1]), .max_err(d_max[1]), .err_sum(d_sum[1]),
        .viol_cnt(d_viol[1]), .pass(d_pass[1]), .first_fail_vec(d_ffv[1]),
        .first_fail_valid(d_ffok[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Sweep results the specification implies for the current mode/table.
    int f_max, f_sum, f_viol, f_ffv, f_ffok;
    task automatic calc();
        int e;
        f_max = 0; f_sum = 0; f_viol = 0; f_ffv = 0; f_ffok = 0;
        for (int v = 0; v < 64; v++) begin
            e = ex(v) - int'(fval(mode, 6'(v), rtab[v]));
            if (e < 0) e = -e;
            if (e > f_max) f_max = e;
            f_sum += e;
            if (e > ET) begin
                f_viol++;
                if (f_ffok == 0) begin f_ffv = v; f_ffok = 1; end
            end
        end
    endtask

    // Model: m_k is the cycle index since the accepted start (0 = idle).
    int m_k [2];
    int m_max [2], m_sum [2], m_viol [2], m_ffv [2], m_ffok [2];
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int lat;
            lat = (i == 0) ? 0 : 2;
            if (rst) begin
                m_k[i] = 0; m_max[i] = 0; m_sum[i] = 0; m_viol[i] = 0; m_ffv[i] = 0; m_ffok[i] = 0;
            end else if (m_k[i] == 0) begin
                if (start) m_k[i] = 1;
            end else begin
                m_k[i]++;
                if (m_k[i] == 65 + lat) begin
                    m_max[i] = f_max; m_sum[i] = f_sum; m_viol[i] = f_viol;
                    m_ffv[i] = f_ffv; m_ffok[i] = f_ffok;
                end else if (m_k[i] > 65 + lat) begin
                    m_k[i] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                int  lat, k, ev;
                bit  eb;
                lat = (i == 0) ? 0 : 2;
                k   = m_k[i];
                eb  = (k >= 1) && (k <= 64 + lat);
                ev  = (k >= 1 && k <= 64) ? k - 1 : (eb ? 63 : 0);
                check($sformatf("busy[%0d]", i), 32'(d_busy[i]), 32'(eb));
                check($sformatf("done[%0d]", i), 32'(d_done[i]), 32'(k == 65 + lat));
                check($sformatf("vec_out[%0d]", i), 32'(d_vec[i]), 32'(ev));
                if (!eb) begin
                    check($sformatf("max_err[%0d]", i), 32'(d_max[i]), 32'(m_max[i]));
                    check($sformatf("err_sum[%0d]", i), 32'(d_sum[i]), 32'(m_sum[i]));
                    check($sformatf("viol_cnt[%0d]", i), 32'(d_viol[i]), 32'(m_viol[i]));
                    check($sformatf("pass[%0d]", i), 32'(d_pass[i]), 32'(m_max[i] <= ET));
`ifdef MADD_CHK_TRACE_EN
                    check($sformatf("ffv[%0d]", i), 32'(d_ffv[i]), 32'(m_ffv[i]));
                    check($sformatf("ffok[%0d]", i), 32'(d_ffok[i]), 32'(m_ffok[i]));
`else
                    check($sformatf("ffv[%0d]", i), 32'(d_ffv[i]), 32'd0);
                    check($sformatf("ffok[%0d]", i), 32'(d_ffok[i]), 32'd0);
`endif
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_mode(input int md);
        mode = md;
        for (int v = 0; v < 64; v++) rtab[v] = 4'($urandom_range(0, 15));
        calc();
    endtask

    // One full sweep; optional start pulses while busy and during the DONE cycle.
    task automatic sweep(input int md, input bit disturb);
        int n0, n2;
        n0 = 0; n2 = 0;
        set_mode(md);
        start = 1'b1;
        tick();
        for (int n = 1; n <= 200; n++) begin
            start = disturb && (n == 20 || n == 65);
            if (d_done[0] && n0 == 0) n0 = n;
            if (d_done[1] && n2 == 0) n2 = n;
            if (n0 != 0 && n2 != 0) break;
            tick();
        end
        start = 1'b0;
        check("start_to_done_lat0", 32'(n0), 32'd65);
        check("start_to_done_lat2", 32'(n2), 32'd67);
        tick();
        tick();
    endtask

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; mode = 0;
        for (int v = 0; v < 64; v++) rtab[v] = 4'd0;
        calc();
        tick(); tick(); tick();
        chk_en = 1'b1;
        check("reset_pass", 32'(d_pass[0]), 32'd1);
        check("reset_max", 32'(d_max[1]), 32'd0);
        rst = 1'b0;
        tick();

        sweep(0, 1'b0);
        check("exact_max", 32'(d_max[0]), 32'd0);
        check("exact_sum", 32'(d_sum[0]), 32'd0);
        check("exact_pass_lat2", 32'(d_pass[1]), 32'd1);
        check("exact_sum_lat2", 32'(d_sum[1]), 32'd0);

        sweep(1, 1'b0);
        check("zero_max", 32'(d_max[0]), 32'd12);
        check("zero_sum", 32'(d_sum[0]), 32'd240);
        check("zero_viol", 32'(d_viol[0]), 32'd11);
        check("zero_pass", 32'(d_pass[0]), 32'd0);
        check("zero_viol_lat2", 32'(d_viol[1]), 32'd11);
`ifdef MADD_CHK_TRACE_EN
        check("zero_ffv", 32'(d_ffv[0]), 32'd15);
        check("zero_ffok", 32'(d_ffok[0]), 32'd1);
`endif

        sweep(2, 1'b1);
        check("ones_max", 32'(d_max[0]), 32'd15);
        check("ones_sum", 32'(d_sum[0]), 32'd720);
        check("ones_viol", 32'(d_viol[0]), 32'd58);
        check("ones_sum_lat2", 32'(d_sum[1]), 32'd720);

        for (int s = 0; s < 3; s++) sweep(3, s[0]);

        // Abort at vector 30 with start held alongside rst; no done may follow.
        set_mode(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 0;
        for (int n = 0; n < 100 && d_vec[0] != 6'd30; n++) tick();
        check("reached_vec30", 32'(d_vec[0]), 32'd30);
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        check("abort_max_cleared", 32'(d_max[0]), 32'd0);
        check("abort_busy", 32'(d_busy[1]), 32'd0);
        for (int n = 0; n < 80; n++) begin
            if (d_done[0] || d_done[1]) seen++;
            tick();
        end
        check("abort_no_done", 32'(seen), 32'd0);
        sweep(3, 1'b1);
        sweep(0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/madd_err_checker.md
MADD_ERR_CHECKER -- requirements
Module: madd_err_checker

Interface
REQ-001 Parameter DUT_LAT, default 0: cycles from vec_out to matching approx_in; legal range 0..3.
REQ-002 Parameter ET, default 6: error threshold; 4-bit unsigned.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin an exhaustive sweep.
REQ-006 vec_out  output  6  stimulus to approximate madd circuit; bit k drives in<k>.
REQ-007 approx_in  input  4  approximate circuit result; bit k from out<k>.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  one-cycle pulse at sweep completion.
REQ-010 max_err  output  4  largest absolute error of the sweep.
REQ-011 err_sum  output  10  sum of absolute errors over 64 vectors.
REQ-012 viol_cnt  output  7  count of vectors with error > ET.
REQ-013 pass  output  1  high when max_err <= ET.
REQ-014 first_fail_vec  output  6  first vector with error > ET (see Configuration).
REQ-015 first_fail_valid  output  1  first_fail_vec holds a captured vector.

Function
REQ-016 Exact reference: a={vec[1],vec[0]}, b={vec[3],vec[2]}, c={vec[5],vec[4]}; exact = a*b+c, 4 bits, range 0..12.
REQ-017 Error = |exact - approx_in|, 4-bit unsigned, computed without wrap.
REQ-018 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-019 IDLE: start high -> RUN next cycle; accumulators, counter, and first-fail capture cleared on that transition.
REQ-020 RUN: vec_out = counter, starts at 0, +1 per cycle; after vector 63 -> DRAIN if DUT_LAT>0, else DONE.
REQ-021 DRAIN: DUT_LAT cycles; vec_out holds 63; then -> DONE.
REQ-022 DONE: done=1 for exactly one cycle; -> IDLE.
REQ-023 Expected values are delayed through a DUT_LAT-deep pipeline with a valid bit; each approx_in sample is compared only when the valid bit is set; exactly 64 comparisons per sweep.
REQ-024 Timing: start sampled in cycle T -> busy high T+1..T+64+DUT_LAT; done in T+65+DUT_LAT.
REQ-025 max_err, err_sum, viol_cnt, pass update from comparisons; final values are stable from the done cycle until the next accepted start.
REQ-026 start while busy or in DONE is ignored.
REQ-027 err_sum cannot overflow (max 960); viol_cnt max 64.
REQ-028 vec_out = 0 in IDLE and DONE.

Reset
REQ-029 rst -> state IDLE, counter 0, pipeline valid bits 0, vec_out 0, busy 0, done 0, max_err 0, err_sum 0, viol_cnt 0, pass 1, first_fail_vec 0, first_fail_valid 0.
REQ-030 rst asserted mid-sweep aborts the sweep; no done pulse; rst has priority over start.

Configuration
REQ-031 Macro MADD_CHK_TRACE_EN defined: on the first comparison with error > ET, first_fail_vec captures that vector index and first_fail_valid is set; both hold until the next accepted start or rst.
REQ-032 Macro undefined: capture logic is absent; first_fail_vec and first_fail_valid are tied to 0; all other behaviour is identical.

Verification
REQ-033 DUT_LAT=0, approx_in = exact; start -> done 65 cycles after start, max_err=0, err_sum=0, viol_cnt=0, pass=1.
REQ-034 DUT_LAT=0, approx_in stuck at 0 -> max_err=12, err_sum=240, viol_cnt=11, pass=0; with MADD_CHK_TRACE_EN, first_fail_vec=15, first_fail_valid=1.
REQ-035 DUT_LAT=0, approx_in stuck at 15 -> max_err=15, err_sum=720, viol_cnt=58, pass=0.
REQ-036 DUT_LAT=2, approx_in = exact delayed 2 cycles -> zero errors, pass=1, done 67 cycles after start.
REQ-037 rst asserted at vector 30, then start -> no done from the aborted sweep; new sweep starts at vector 0 with cleared results; start pulses during busy do not restart the sweep.
